// File: rtl/enemy_pkg.sv
// Shared constants and types for the enemy sprite renderer.
package enemy_pkg;
  localparam logic [7:0] X_POS0 = 8'd20;
  localparam logic [7:0] X_POS1 = 8'd60;
  localparam logic [7:0] X_POS2 = 8'd100;
  localparam int         SPRITE_W = 16;
  localparam int         SPRITE_H = 24;
  localparam logic [6:0] Y_TOP = 7'd40;
  localparam logic [7:0] X_MAX = 8'd144;

  localparam logic [2:0] BLACK = 3'b000;
  localparam logic [2:0] WHITE = 3'b111;
  localparam logic [2:0] RED   = 3'b100;

  typedef enum logic [2:0] {START, IDLE, LOAD, ERASE, DRAW, DONE} state_e;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
  } pixel_t;

  // Keeps the right edge of the sprite inside the 160-pixel screen.
  function automatic logic [7:0] clamp_x(input logic [7:0] x);
    return (x > X_MAX) ? X_MAX : x;
  endfunction

  function automatic logic [2:0] draw_colour(input logic att);
    return att ? RED : WHITE;
  endfunction
endpackage

// File: rtl/enemy_draw_if.sv
// Datapath-side request and VGA-side pixel bus of the enemy renderer.
interface enemy_draw_if;
  logic [7:0] x_in;
  logic       move;
  logic       attacking;
  logic [7:0] x_out;
  logic [6:0] y_out;
  logic [2:0] colour;
  logic       plot;
  logic       busy;
  logic       done;

  modport master (output x_in, move, attacking,
                  input  x_out, y_out, colour, plot, busy, done);
  modport slave  (input  x_in, move, attacking,
                  output x_out, y_out, colour, plot, busy, done);
endinterface

// File: rtl/enemy_draw_pixel_counter.sv
// Raster scan over the sprite: col fastest, then row; wraps to (0,0).
module pixel_counter
  import enemy_pkg::*;
(
  input  logic       clock,
  input  logic       resetn,
  input  logic       clear,
  input  logic       enable,
  output logic [3:0] col,
  output logic [4:0] row,
  output logic       last
);
  logic [3:0] col_q;
  logic [4:0] row_q;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      col_q <= '0;
      row_q <= '0;
    end else if (clear) begin
      col_q <= '0;
      row_q <= '0;
    end else if (enable) begin
      if (col_q == 4'(SPRITE_W - 1)) begin
        col_q <= '0;
        row_q <= (row_q == 5'(SPRITE_H - 1)) ? 5'd0 : row_q + 5'd1;
      end else begin
        col_q <= col_q + 4'd1;
      end
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign last = (col_q == 4'(SPRITE_W - 1)) && (row_q == 5'(SPRITE_H - 1));
endmodule

// File: rtl/enemy_draw.sv
// Enemy sprite renderer: erases the old sprite, draws the new one, one pixel per cycle.
module enemy_draw
  import enemy_pkg::*;
(
  input  logic         clock,
  input  logic         resetn,
  enemy_draw_if.slave  bus
);
  state_e     state_q;
  logic [7:0] old_x_q, new_x_q, base_q;
  logic       att_q, last_att_q, pend_q;
  logic       busy_q, done_q, plot_q;
  logic [2:0] colour_q;

  logic       cnt_clr, cnt_last;
  logic [3:0] col;
  logic [4:0] row;
  logic [7:0] x_ld;
  logic       same;
  pixel_t     pix;

  assign x_ld = clamp_x(bus.x_in);
  assign same = (x_ld == old_x_q) && (bus.attacking == last_att_q);

  // Counter restarts at the top-left corner whenever a pass is about to begin.
  assign cnt_clr = (state_q == START) || (state_q == LOAD) ||
                   ((state_q == ERASE) && cnt_last);

  pixel_counter u_cnt (
    .clock  (clock),
    .resetn (resetn),
    .clear  (cnt_clr),
    .enable (plot_q),
    .col    (col),
    .row    (row),
    .last   (cnt_last)
  );

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q    <= START;
      old_x_q    <= X_POS0;
      new_x_q    <= X_POS0;
      base_q     <= '0;
      att_q      <= 1'b0;
      last_att_q <= 1'b0;
      pend_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      plot_q     <= 1'b0;
      colour_q   <= BLACK;
    end else begin
      done_q <= 1'b0;
      // A request that arrives mid-redraw is merged into one follow-up pass.
      if (bus.move && (state_q != IDLE) && (state_q != DONE)) pend_q <= 1'b1;
      case (state_q)
        START: begin
          state_q  <= DRAW;
          busy_q   <= 1'b1;
          plot_q   <= 1'b1;
          base_q   <= new_x_q;
          colour_q <= draw_colour(att_q);
        end
        IDLE: begin
          if (bus.move) begin
            state_q <= LOAD;
            busy_q  <= 1'b1;
          end
        end
        LOAD: begin
          new_x_q <= x_ld;
          att_q   <= bus.attacking;
          if (same) begin
            state_q <= DONE;
            done_q  <= 1'b1;
          end else begin
            state_q  <= ERASE;
            plot_q   <= 1'b1;
            base_q   <= old_x_q;
            colour_q <= BLACK;
          end
        end
        ERASE: begin
          if (cnt_last) begin
            state_q  <= DRAW;
            base_q   <= new_x_q;
            colour_q <= draw_colour(att_q);
          end
        end
        DRAW: begin
          if (cnt_last) begin
            state_q    <= DONE;
            plot_q     <= 1'b0;
            base_q     <= '0;
            colour_q   <= BLACK;
            done_q     <= 1'b1;
            old_x_q    <= new_x_q;
            last_att_q <= att_q;
          end
        end
        DONE: begin
          pend_q <= 1'b0;
          if (pend_q || bus.move) begin
            state_q <= LOAD;
          end else begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= START;
      endcase
    end
  end

  always_comb begin
    pix = '0;
    if (plot_q) begin
      pix.x      = base_q + {4'd0, col};
      pix.y      = Y_TOP + {2'd0, row};
      pix.colour = colour_q;
    end
  end

  assign bus.x_out  = pix.x;
  assign bus.y_out  = pix.y;
  assign bus.colour = pix.colour;
  assign bus.plot   = plot_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
endmodule

// File: doc/enemy_draw.md
ENEMY_DRAW -- requirements
Module: enemy_draw

Interface
REQ-001 SHALL have port: clock  in  1  single system clock, all state on rising edge.
REQ-002 SHALL have port: resetn  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: x_in  in  8  enemy x position from the enemy datapath (nominal 20/60/100).
REQ-004 SHALL have port: move  in  1  single-cycle redraw request from the enemy datapath.
REQ-005 SHALL have port: attacking  in  1  sprite colour select, 1 = attack pose.
REQ-006 SHALL have port: x_out  out  8  VGA adapter pixel x.
REQ-007 SHALL have port: y_out  out  7  VGA adapter pixel y.
REQ-008 SHALL have port: colour  out  3  VGA adapter pixel colour.
REQ-009 SHALL have port: plot  out  1  pixel write strobe.
REQ-010 SHALL have port: busy  out  1  high in every state except IDLE.
REQ-011 SHALL have port: done  out  1  one-cycle pulse at end of each redraw.

Function
REQ-012 SHALL implement FSM states START, IDLE, LOAD, ERASE, DRAW, DONE.
REQ-013 Sprite SHALL be 16 wide x 24 high, top edge at y = 40; pixel = (base_x + col, 40 + row).
REQ-014 Scan order SHALL be col 0..15 fastest, then row 0..23; one pixel per cycle; 384 cycles per pass.
REQ-015 plot SHALL be 1 only in ERASE and DRAW; x_out, y_out, colour SHALL be 0 whenever plot = 0.
REQ-016 ERASE SHALL scan at old_x with colour 000; DRAW SHALL scan at new_x with colour 100 if latched attacking = 1, else 111.
REQ-017 IDLE with move = 1 SHALL go to LOAD; LOAD latches new_x = x_in (clamped to 144 if greater) and attacking, for exactly one cycle.
REQ-018 LOAD SHALL go to ERASE, except when new_x = old_x and attacking equals the last drawn value, then directly to DONE (no pixels).
REQ-019 ERASE SHALL go to DRAW after pixel (15,23); DRAW SHALL go to DONE after pixel (15,23) and set old_x = new_x, last attacking = latched value.
REQ-020 Timing: move high in cycle c (IDLE) -> LOAD at c+1, ERASE c+2..c+385, DRAW c+386..c+769, done = 1 at c+770, IDLE at c+771.
REQ-021 move asserted while busy SHALL set a pending flag (multiple requests merge into one); DONE with pending set SHALL go to LOAD (clearing pending, sampling x_in then), else to IDLE.
REQ-022 move in the same cycle as DONE SHALL be treated as pending (no request lost).
REQ-023 Pixel counters SHALL wrap col 15 -> 0 with row increment, and reset to (0,0) on every pass entry.

Reset
REQ-024 resetn low SHALL force state START, counters 0, old_x = 20, last attacking = 0, pending = 0, and all outputs 0 (busy, done, plot, x_out, y_out, colour) immediately, independent of clock.
REQ-025 After release, START SHALL last one cycle then run DRAW only (no ERASE) at x = 20, colour 111, followed by DONE and IDLE.
REQ-026 Reset asserted mid-ERASE or mid-DRAW SHALL abandon the pass with no further plot pulses.

Structure
REQ-027 Shared package enemy_pkg SHALL hold: position constants 20/60/100, SPRITE_W = 16, SPRITE_H = 24, Y_TOP = 40, X_MAX = 144, colour constants BLACK/WHITE/RED, and the FSM state type.
REQ-028 Col/row scanning SHALL be one sub-module, pixel_counter (clear, enable, col, row, last), instantiated once.

Verification
REQ-029 Reset release -> 384 plot pulses at x 20..35, y 40..63, colour 111, then done pulse, busy = 0.
REQ-030 x_in = 60, move pulse at cycle c -> 384 plots colour 000 at x 20..35, then 384 plots colour 111 at x 60..75, done at c+770.
REQ-031 x_in = 60 unchanged, attacking 0 -> 1, move -> erase at 60, draw colour 100 at 60; repeat with same inputs -> LOAD then DONE, zero plot pulses.
REQ-032 Three move pulses during a redraw, x_in = 100 at DONE -> exactly one extra redraw, drawn at x 100..115.
REQ-033 x_in = 200, move -> draw at x 144..159, no x_out above 159.
REQ-034 resetn low at pixel 200 of DRAW -> plot 0 same cycle; after release, initial draw at x = 20 repeats as REQ-029.
